// File: rtl/sift_buf_pkg.sv
// Shared types for the line buffer: the operating-mode encodings and the flush FSM state.
package sift_buf_pkg;

  typedef enum logic [1:0] {
    MODE_IDLE  = 2'd0,
    MODE_CHAIN = 2'd1,
    MODE_GROUP = 2'd2,
    MODE_HOLD  = 2'd3
  } mode_t;

  typedef enum logic {
    S_RUN   = 1'b0,
    S_FLUSH = 1'b1
  } state_t;

endpackage

// File: rtl/lb_flush_ctrl.sv
// Flush sequencer: counts PAD zero-row shifts and reports busy while a flush is active.
module lb_flush_ctrl
  import sift_buf_pkg::*;
#(
  parameter int PAD = 2
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   flush,
  input  logic   mode_ok,
  input  logic   clear,
  input  logic   mode_chg,
  output logic   busy,
  output logic   zero_shift,
  output state_t state
);

  localparam int CW = $clog2(PAD + 1);

  state_t        state_n;
  logic [CW-1:0] cnt, cnt_n;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_RUN;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // A mode outside CHAIN/GROUP freezes the sequence so a HOLD pauses it in place.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    zero_shift = 1'b0;
    if (clear || mode_chg) begin
      state_n = S_RUN;
      cnt_n   = '0;
    end else if (mode_ok) begin
      case (state)
        S_RUN: begin
          if (flush) begin
            state_n = S_FLUSH;
            cnt_n   = CW'(PAD);
          end
        end
        S_FLUSH: begin
          zero_shift = 1'b1;
          cnt_n      = cnt - 1'b1;
          if (cnt == CW'(1)) state_n = S_RUN;
        end
        default: state_n = S_RUN;
      endcase
    end
  end

  assign busy = (state == S_FLUSH);

endmodule

// File: rtl/line_buffer_param.sv
// Parameterised row line buffer: one DEPTH-row chain or NCH independent groups,
// with zero-row flush, hold and clear.
module line_buffer_param
  import sift_buf_pkg::*;
#(
  parameter int ROW_W = 5120,
  parameter int DEPTH = 10,
  parameter int NCH   = 5,
  parameter int PAD   = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [1:0]                 mode,
  input  logic                       clear,
  input  logic                       push,
  input  logic [ROW_W-1:0]           row_in,
  input  logic [NCH*ROW_W-1:0]       ch_in,
  input  logic                       flush,
  output logic                       busy,
  output logic                       win_valid,
  output logic [$clog2(DEPTH+1)-1:0] row_cnt,
  output logic [DEPTH*ROW_W-1:0]     win_data
);

  localparam int G  = DEPTH / NCH;
  localparam int CW = $clog2(DEPTH + 1);

  logic       mode_ok, prev_ok, mode_chg, mode_idle, zero_rows;
  logic       zero_shift, push_ok, shift_en;
  logic [1:0] prev_mode;
  logic [CW-1:0] lim, cnt_n;
  logic       valid_n;
  state_t     fsm_state;

  assign mode_ok   = (mode == MODE_CHAIN) || (mode == MODE_GROUP);
  assign prev_ok   = (prev_mode == MODE_CHAIN) || (prev_mode == MODE_GROUP);
  assign mode_chg  = mode_ok && prev_ok && (prev_mode != mode);
  assign mode_idle = (mode == MODE_IDLE);
  assign zero_rows = clear || mode_idle;
  assign lim       = (mode == MODE_GROUP) ? CW'(G) : CW'(DEPTH);

  lb_flush_ctrl #(.PAD(PAD)) u_flush (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .mode_ok    (mode_ok),
    .clear      (zero_rows),
    .mode_chg   (mode_chg),
    .busy       (busy),
    .zero_shift (zero_shift),
    .state      (fsm_state)
  );

  // The cycle that starts a flush takes no data row, so a held push cannot sneak in.
  assign push_ok  = push && !busy && mode_ok && !flush && !zero_rows && !mode_chg;
  assign shift_en = zero_shift || push_ok;

  always_comb begin
    cnt_n = row_cnt;
    if (zero_rows || mode_chg) cnt_n = '0;
    else if (shift_en)         cnt_n = (row_cnt >= lim) ? lim : row_cnt + 1'b1;
    valid_n = mode_ok && (cnt_n == lim);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_mode <= MODE_IDLE;
      row_cnt   <= '0;
      win_valid <= 1'b0;
    end else begin
      prev_mode <= mode;
      row_cnt   <= cnt_n;
      win_valid <= valid_n;
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_row
    logic [ROW_W-1:0] row_q, grp_in, chain_in, nxt;

    if (k % G == 0) begin : g_head
      assign grp_in = zero_shift ? '0 : ch_in[(k/G)*ROW_W +: ROW_W];
    end else begin : g_body
      assign grp_in = g_row[k-1].row_q;
    end

    if (k == 0) begin : g_first
      assign chain_in = zero_shift ? '0 : row_in;
    end else begin : g_rest
      assign chain_in = g_row[k-1].row_q;
    end

    assign nxt = (mode == MODE_GROUP) ? grp_in : chain_in;

    always_ff @(posedge clk) begin
      if (!rst_n || zero_rows) row_q <= '0;
      else if (shift_en)       row_q <= nxt;
    end

    assign win_data[k*ROW_W +: ROW_W] = row_q;
  end

endmodule

// File: tb/tb_line_buffer_param.sv
// Bench for line_buffer_param: directed scenarios plus random traffic checked against a
// cycle-level behavioural model through an expected-value queue.
module tb_line_buffer_param;
  import sift_buf_pkg::*;

  localparam int ROW_W = 8;
  localparam int DEPTH = 4;
  localparam int NCH   = 2;
  localparam int PAD   = 2;
  localparam int G     = DEPTH / NCH;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int W     = 2 + CW + DEPTH * ROW_W;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [1:0]             mode = MODE_IDLE;
  logic                   clear = 1'b0, push = 1'b0, flush = 1'b0;
  logic [ROW_W-1:0]       row_in = '0;
  logic [NCH*ROW_W-1:0]   ch_in = '0;
  logic                   busy, win_valid;
  logic [CW-1:0]          row_cnt;
  logic [DEPTH*ROW_W-1:0] win_data;

  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];

  line_buffer_param #(.ROW_W(ROW_W), .DEPTH(DEPTH), .NCH(NCH), .PAD(PAD)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .clear(clear), .push(push),
    .row_in(row_in), .ch_in(ch_in), .flush(flush), .busy(busy),
    .win_valid(win_valid), .row_cnt(row_cnt), .win_data(win_data)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: rows as an int array, flush as "zero rows still owed".
  int m_rows[DEPTH];
  int m_cnt = 0, m_left = 0, m_prev = 0;
  bit m_valid = 0;

  task automatic m_shift(input int md, input bit zero);
    int old[DEPTH];
    int lim;
    old = m_rows;
    lim = (md == 2) ? G : DEPTH;
    for (int k = 0; k < DEPTH; k++) begin
      if (md == 2) begin
        if (k % G == 0) m_rows[k] = zero ? 0 : int'((ch_in >> ((k / G) * ROW_W)) & 8'hFF);
        else            m_rows[k] = old[k-1];
      end else begin
        if (k == 0) m_rows[k] = zero ? 0 : int'(row_in);
        else        m_rows[k] = old[k-1];
      end
    end
    m_cnt = (m_cnt + 1 > lim) ? lim : m_cnt + 1;
  endtask

  task automatic model_step();
    int md;
    bit ok, pok;
    logic [DEPTH*ROW_W-1:0] d;
    md  = int'(mode);
    ok  = (md == 1) || (md == 2);
    pok = (m_prev == 1) || (m_prev == 2);
    if (!rst_n) begin
      foreach (m_rows[k]) m_rows[k] = 0;
      m_cnt = 0; m_left = 0; m_prev = 0; m_valid = 0;
    end else begin
      if (clear || md == 0) begin
        foreach (m_rows[k]) m_rows[k] = 0;
        m_cnt = 0; m_left = 0;
      end else if (ok && pok && m_prev != md) begin
        m_cnt = 0; m_left = 0;
      end else if (ok) begin
        if (m_left > 0) begin
          m_shift(md, 1'b1);
          m_left--;
        end else if (flush) m_left = PAD;
        else if (push)      m_shift(md, 1'b0);
      end
      m_prev  = md;
      m_valid = ok && (m_cnt == ((md == 2) ? G : DEPTH));
    end
    d = '0;
    for (int k = 0; k < DEPTH; k++) d[k*ROW_W +: ROW_W] = ROW_W'(m_rows[k]);
    exp_q.push_back({m_left > 0, m_valid, CW'(m_cnt), d});
  endtask

  always @(posedge clk) model_step();

  // scoreboard
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("sb_data",  win_data,  e[DEPTH*ROW_W-1:0]);
      check("sb_cnt",   row_cnt,   e[DEPTH*ROW_W +: CW]);
      check("sb_valid", win_valid, e[W-2]);
      check("sb_busy",  busy,      e[W-1]);
    end
  end

  // driver: apply inputs for one cycle, return after the edge has been observed
  task automatic drive(input logic r, input logic [1:0] md, input logic c, input logic p,
                       input logic f, input logic [ROW_W-1:0] ri, input logic [NCH*ROW_W-1:0] ci);
    rst_n = r; mode = md; clear = c; push = p; flush = f; row_in = ri; ch_in = ci;
    @(negedge clk);
  endtask

  initial begin
    logic [1:0] mr;
    @(negedge clk);
    drive(0, MODE_IDLE, 0, 0, 0, 8'h00, 16'h0);
    check("rst_data", win_data, 32'h0);
    check("rst_cnt", row_cnt, 3'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_valid", win_valid, 1'b0);

    // CHAIN fill
    drive(1, MODE_CHAIN, 0, 1, 0, 8'h11, 16'h0);
    drive(1, MODE_CHAIN, 0, 1, 0, 8'h22, 16'h0);
    drive(1, MODE_CHAIN, 0, 1, 0, 8'h33, 16'h0);
    check("chain_valid3", win_valid, 1'b0);
    drive(1, MODE_CHAIN, 0, 1, 0, 8'h44, 16'h0);
    check("chain_data", win_data, 32'h11223344);
    check("chain_cnt", row_cnt, 3'd4);
    check("chain_valid", win_valid, 1'b1);

    // flush with push held
    drive(1, MODE_CHAIN, 0, 1, 1, 8'h55, 16'h0);
    check("flush_busy1", busy, 1'b1);
    check("flush_hold", win_data, 32'h11223344);
    drive(1, MODE_CHAIN, 0, 1, 0, 8'h55, 16'h0);
    check("flush_busy2", busy, 1'b1);
    check("flush_z1", win_data, 32'h22334400);
    drive(1, MODE_CHAIN, 0, 1, 0, 8'h55, 16'h0);
    check("flush_done", busy, 1'b0);
    check("flush_data", win_data, 32'h33440000);

    // clear beats push
    drive(1, MODE_CHAIN, 1, 1, 0, 8'h99, 16'h0);
    check("clr_data", win_data, 32'h0);
    check("clr_cnt", row_cnt, 3'd0);

    // mode change CHAIN -> GROUP
    drive(1, MODE_CHAIN, 0, 1, 0, 8'h01, 16'h0);
    drive(1, MODE_CHAIN, 0, 1, 0, 8'h02, 16'h0);
    drive(1, MODE_CHAIN, 0, 1, 0, 8'h03, 16'h0);
    check("mc_pre_cnt", row_cnt, 3'd3);
    drive(1, MODE_GROUP, 0, 1, 0, 8'h00, 16'hEEEE);
    check("mc_cnt", row_cnt, 3'd0);
    check("mc_data", win_data, 32'h00010203);
    check("mc_valid", win_valid, 1'b0);

    // GROUP fill
    drive(1, MODE_GROUP, 0, 1, 0, 8'h00, 16'hB1A1);
    check("grp_valid1", win_valid, 1'b0);
    drive(1, MODE_GROUP, 0, 1, 0, 8'h00, 16'hB2A2);
    check("grp_data", win_data, 32'hB1B2A1A2);
    check("grp_cnt", row_cnt, 3'd2);
    check("grp_valid", win_valid, 1'b1);

    // reset mid-flush
    drive(1, MODE_GROUP, 0, 0, 1, 8'h00, 16'h0);
    check("rf_busy", busy, 1'b1);
    drive(0, MODE_GROUP, 0, 0, 0, 8'h00, 16'h0);
    check("rf_busy0", busy, 1'b0);
    drive(1, MODE_GROUP, 0, 0, 0, 8'h00, 16'h0);
    drive(1, MODE_GROUP, 0, 0, 0, 8'h00, 16'h0);
    check("rf_noshift", row_cnt, 3'd0);
    check("rf_busy_after", busy, 1'b0);

    // random traffic
    mr = MODE_CHAIN;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) mr = 2'($urandom_range(0, 3));
      drive($urandom_range(0, 99) != 0, mr, $urandom_range(0, 39) == 0,
            $urandom_range(0, 9) < 7, $urandom_range(0, 11) == 0,
            8'($urandom), 16'($urandom));
    end
    drive(1, MODE_IDLE, 0, 0, 0, 8'h00, 16'h0);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/line_buffer_param.md
LINE_BUFFER_PARAM -- requirements
Module: line_buffer_param

Interface
REQ-001 Parameters, one per line:
- ROW_W, 5120, bits per row.
- DEPTH, 10, total rows held.
- NCH, 5, channel groups in group mode; DEPTH % NCH == 0 is required.
- PAD, 2, zero rows inserted per flush; must be at least 1.

REQ-002 Ports, one per line:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- mode  in  2  0=IDLE, 1=CHAIN, 2=GROUP, 3=HOLD.
- clear  in  1  zero all rows and counters.
- push  in  1  shift one row in.
- row_in  in  ROW_W  CHAIN-mode input row.
- ch_in  in  NCH*ROW_W  GROUP-mode inputs; slice g feeds group g.
- flush  in  1  start PAD-row zero flush.
- busy  out  1  flush in progress; push is ignored.
- win_valid  out  1  window fully populated.
- row_cnt  out  $clog2(DEPTH+1)  valid rows, saturating.
- win_data  out  DEPTH*ROW_W  row k at bits [k*ROW_W +: ROW_W]; row 0 is newest.

Function
REQ-003 All state updates on the rising edge of clk; win_data, win_valid, row_cnt and busy are registered outputs.
REQ-004 Group size G = DEPTH/NCH; group g holds rows g*G .. g*G+G-1.
REQ-005 Shift event = push accepted (busy=0), or one flush cycle.
REQ-006 CHAIN shift: row 0 <= row_in (zero during flush); row k <= row k-1 for k>0; row DEPTH-1 is discarded.
REQ-007 GROUP shift: head row g*G <= ch_in slice g (zero during flush); other rows in the group take the previous row of the same group; no data crosses group boundaries.
REQ-008 mode=IDLE: every cycle, all rows <= 0, row_cnt <= 0, and the FSM is forced to S_RUN.
REQ-009 mode=HOLD: rows and row_cnt hold; push and flush are ignored; an active flush pauses and resumes on return to CHAIN or GROUP.
REQ-010 FSM states are S_RUN and S_FLUSH; reset state is S_RUN.
REQ-011 S_RUN -> S_FLUSH when flush=1 in mode CHAIN or GROUP; the flush counter loads PAD.
REQ-012 S_FLUSH performs one zero shift per cycle and decrements the counter; it exits to S_RUN on the cycle the PAD-th zero shift occurs.
REQ-013 busy = (state==S_FLUSH).
REQ-014 flush asserted while already in S_FLUSH is ignored; the counter is not reloaded.
REQ-015 push while busy=1 is dropped, with no side effect.
REQ-016 row_cnt increments by 1 per shift event and saturates at LIM, where LIM=DEPTH in CHAIN and LIM=G in GROUP; zero-row shifts count.
REQ-017 win_valid = (row_cnt == LIM) for the current mode; win_valid=0 in IDLE and HOLD.
REQ-018 Any change of mode between CHAIN and GROUP (registered previous mode != mode) zeroes row_cnt that cycle, aborts any flush to S_RUN, and performs no shift; row data is retained.
REQ-019 Priority, highest first: rst_n low, clear, mode=IDLE, mode change, flush/shift.
REQ-020 clear=1 zeroes all rows, zeroes row_cnt, forces S_RUN, and suppresses a simultaneous push or flush.

Reset
REQ-021 rst_n=0 at a clk edge sets: all rows to 0, row_cnt=0, win_valid=0, busy=0, state=S_RUN, flush counter=0, registered previous mode=IDLE.
REQ-022 Reset during S_FLUSH abandons the flush; no zero rows are inserted after rst_n returns high.

Structure
REQ-023 Shared package sift_buf_pkg holds:
- the mode encodings (MODE_IDLE/CHAIN/GROUP/HOLD);
- the FSM state type.
REQ-024 The PAD flush counter is sub-module lb_flush_ctrl; it takes flush, mode_ok, clear and mode_chg and outputs busy and zero_shift.
REQ-025 The row array is built with generate loops over DEPTH; no per-row hand-coded logic.

Verification
All scenarios use ROW_W=8, DEPTH=4, NCH=2, PAD=2.
REQ-026 CHAIN: push 0x11, 0x22, 0x33, 0x44 on consecutive cycles -> win_data rows 0..3 = 44, 33, 22, 11; row_cnt=4; win_valid=1 after the 4th edge.
REQ-027 GROUP: push with ch_in={0xB1,0xA1}, then {0xB2,0xA2} -> rows 0..3 = A2, A1, B2, B1; row_cnt=2; win_valid=1.
REQ-028 Flush: after REQ-026, pulse flush, and hold push=1 with row_in=0x55 -> busy=1 for 2 cycles; rows = 00, 00, 44, 33; 0x55 is never loaded.
REQ-029 Mode change: CHAIN with row_cnt=3, switch to GROUP with push=1 -> row_cnt=0, data unchanged, win_valid=0 that cycle.
REQ-030 Clear and reset: with clear=1 and push=1 simultaneously -> all rows 0, row_cnt=0. Separately, rst_n=0 mid-flush -> busy=0 next cycle; no further zero shifts after release.
